lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//  Receive-side PRBS checker for the LFSR pattern generator. Self-synchronises to a serial
//  Fibonacci-LFSR bitstream, then free-runs a local LFSR and flags every mismatching bit.
//  Sits at the sink of a loopback/link-test path. Reports lock status, error and checked-bit counts for BER.
// PARAMETERS
//  N            8             LFSR length in bits
//  TAPS         8'b00000011   feedback mask (bit i set -> history bit i XORed); must equal generator TAPS
//  LOCK_COUNT   16            consecutive correct predictions required to declare lock
//  WIN          64            unlock observation window, in checked bits
//  UNLOCK_ERRS  8             errors within one window that force loss of lock (1..WIN)
//  CNT_W        32            width of err_count_o and bit_count_o
// PORTS
//  clk_i        in   1      clock
//  reset_i      in   1      asynchronous reset, active-high
//  valid_i      in   1      data_i carries a stream bit this cycle
//  data_i       in   1      serial PRBS bit, oldest first (same order as generator data_o)
//  clear_i      in   1      synchronous clear of err_count_o/bit_count_o; lock state untouched
//  locked_o     out  1      checker locked to the stream
//  error_o      out  1      one-cycle pulse: last accepted bit mismatched while locked
//  err_count_o  out  CNT_W  mismatches counted while locked, saturating
//  bit_count_o  out  CNT_W  bits checked while locked, saturating
// BEHAVIOUR
//  Reset: state=FILL; history, fill/match/window counters = 0; locked_o=0; error_o=0; both counts = 0.
//  History hist[N-1:0]: on each shift, hist <= {b, hist[N-1:1]}; prediction p = ^(hist & TAPS).
//   (Generator relation: s[k+N] = XOR over i of TAPS[i]*s[k+i].)
//  Only cycles with valid_i=1 advance any state; valid_i=0 cycles hold everything and deassert error_o.
//  FILL: b=data_i. Count N accepted bits, then go to SYNC with match=0. No compare.
//  SYNC: compare data_i with p. Shift data_i in (self-synchronising).
//   - Match and hist != 0: match++. Reaching LOCK_COUNT -> LOCKED; locked_o=1 next cycle; window counters cleared.
//   - Mismatch, or hist == 0 (degenerate all-zero state): match=0.
//  LOCKED: compare data_i with p. Shift p in (free-run), not data_i, so errors do not corrupt history.
//   - bit_count++. On mismatch: error_o=1 next cycle; err_count++. Both counts saturate at 2^CNT_W-1.
//   - Window: count checked bits and window errors. When errors reach UNLOCK_ERRS inside the window:
//     go to FILL and drop locked_o the next cycle. The error_o pulse for that bit still fires.
//   - At the end of each WIN bits, reset both window counters.
//   - Counts hold their values after loss of lock.
//  Latency: locked_o, error_o and counts are registered, updated the cycle after the accepting clock edge.
//  clear_i: counts <= 0 next cycle. If clear_i coincides with an increment, the clear wins (result 0).
//  Asynchronous reset mid-operation returns to FILL immediately. Outputs go to their reset values.
// TESTING
//  Generator N=8, TAPS=8'b00000011, START=1 drives data_i with valid_i=1 continuously.
//  T1 clean stream -> locked_o rises 1 cycle after the 24th valid bit (8 fill + 16 match);
//     after 1000 further bits: err_count_o=0, bit_count_o=1000.
//  T2 locked, invert one bit -> single error_o pulse, err_count_o=1, locked_o stays 1.
//     The next bit is checked correctly (no error multiplication).
//  T3 locked, invert 8 consecutive bits -> error_o high 8 cycles, err_count_o=8.
//     locked_o=0 the cycle after the 8th error, then relock after 24 clean bits.
//  T4 random valid_i gaps (~50%) on a clean stream -> lock after 24 valid bits, zero errors, counts unaffected by gaps.
//  T5 data_i held 0 -> locked_o never asserts. Then apply the clean stream -> lock after 24 bits.
//  T6 clear_i while locked with err_count_o=3 -> both counts 0 next cycle, lock held.
//     Assert reset_i mid-stream -> locked_o=0 without a clock edge.
//     Saturation check with CNT_W=4: 20 errors -> err_count_o=15.

Source files
------------

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_checker
//  Purpose  : Receive-side PRBS checker for a serial Fibonacci-LFSR stream.
//             Self-synchronises by loading received bits into a local history.
//             Once locked, it free-runs the local LFSR and flags every bit
//             that differs from the prediction.
//  Ports    : clk_i        clock
//             reset_i      asynchronous reset, active-high
//             valid_i      data_i carries a stream bit this cycle
//             data_i       serial PRBS bit, oldest first
//             clear_i      synchronous clear of both counters (lock untouched)
//             locked_o     checker locked to the stream
//             error_o      one-cycle pulse: last accepted bit mismatched (locked)
//             err_count_o  saturating mismatch count while locked
//             bit_count_o  saturating checked-bit count while locked
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_checker #(
   parameter int           N           = 8,
   parameter logic [N-1:0] TAPS        = 8'b00000011,
   parameter int           LOCK_COUNT  = 16,
   parameter int           WIN         = 64,
   parameter int           UNLOCK_ERRS = 8,
   parameter int           CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             valid_i,
   input  logic             data_i,
   input  logic             clear_i,
   output logic             locked_o,
   output logic             error_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic [CNT_W-1:0] bit_count_o
);

   localparam int FILL_W  = $clog2(N + 1);
   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int WB_W    = $clog2(WIN + 1);
   localparam int WE_W    = $clog2(UNLOCK_ERRS + 1);

   localparam logic [FILL_W-1:0]  FILL_LAST   = FILL_W'(N - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [WB_W-1:0]    WIN_LAST    = WB_W'(WIN - 1);
   localparam logic [WE_W-1:0]    UNLOCK_LAST = WE_W'(UNLOCK_ERRS - 1);

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t             state_q;
   logic [N-1:0]       hist_q;        // hist_q[0] is the oldest bit
   logic [FILL_W-1:0]  fill_q;
   logic [MATCH_W-1:0] match_q;
   logic [WB_W-1:0]    win_bits_q;
   logic [WE_W-1:0]    win_errs_q;
   logic               locked_q;
   logic               error_q;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

   logic pred;
   logic mismatch;
   logic hist_nz;

   assign pred     = ^(hist_q & TAPS);
   assign mismatch = data_i ^ pred;
   // An all-zero history predicts zeros forever, so it must never count toward lock.
   assign hist_nz  = |hist_q;

   // Counter next-state; clear_i takes priority over a coincident increment.
   always_comb begin
      err_cnt_d = err_cnt_q;
      bit_cnt_d = bit_cnt_q;
      if (valid_i && (state_q == ST_LOCKED)) begin
         if (bit_cnt_q != '1)
            bit_cnt_d = bit_cnt_q + 1'b1;
         if (mismatch && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + 1'b1;
      end
      if (clear_i) begin
         err_cnt_d = '0;
         bit_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_FILL;
         hist_q     <= '0;
         fill_q     <= '0;
         match_q    <= '0;
         win_bits_q <= '0;
         win_errs_q <= '0;
         locked_q   <= 1'b0;
         error_q    <= 1'b0;
         err_cnt_q  <= '0;
         bit_cnt_q  <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         error_q   <= 1'b0;
         if (valid_i) begin
            case (state_q)
               ST_FILL: begin
                  hist_q <= {data_i, hist_q[N-1:1]};
                  if (fill_q == FILL_LAST) begin
                     state_q <= ST_SYNC;
                     fill_q  <= '0;
                     match_q <= '0;
                  end else begin
                     fill_q <= fill_q + 1'b1;
                  end
               end
               ST_SYNC: begin
                  hist_q <= {data_i, hist_q[N-1:1]};
                  if (!mismatch && hist_nz) begin
                     if (match_q == MATCH_LAST) begin
                        state_q    <= ST_LOCKED;
                        locked_q   <= 1'b1;
                        match_q    <= '0;
                        win_bits_q <= '0;
                        win_errs_q <= '0;
                     end else begin
                        match_q <= match_q + 1'b1;
                     end
                  end else begin
                     match_q <= '0;
                  end
               end
               ST_LOCKED: begin
                  // Free-run on the prediction so a corrupted bit cannot
                  // poison the history and multiply into later errors.
                  hist_q  <= {pred, hist_q[N-1:1]};
                  error_q <= mismatch;
                  if (mismatch && (win_errs_q == UNLOCK_LAST)) begin
                     state_q    <= ST_FILL;
                     locked_q   <= 1'b0;
                     fill_q     <= '0;
                     win_bits_q <= '0;
                     win_errs_q <= '0;
                  end else if (win_bits_q == WIN_LAST) begin
                     win_bits_q <= '0;
                     win_errs_q <= '0;
                  end else begin
                     win_bits_q <= win_bits_q + 1'b1;
                     if (mismatch)
                        win_errs_q <= win_errs_q + 1'b1;
                  end
               end
               default: begin
                  state_q  <= ST_FILL;
                  locked_q <= 1'b0;
                  fill_q   <= '0;
               end
            endcase
         end
      end
   end

   assign locked_o    = locked_q;
   assign error_o     = error_q;
   assign err_count_o = err_cnt_q;
   assign bit_count_o = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_checker
//  Purpose  : Directed testbench for lfsr_checker with a queue-based
//             reference model compared every cycle. A second instance with
//             4-bit counters covers saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lfsr_checker;

   localparam int         N          = 8;
   localparam logic [7:0] TAPS       = 8'b00000011;
   localparam int         LOCK_COUNT = 16;
   localparam int         WIN        = 64;
   localparam int         UNLOCK     = 8;

   logic clk = 1'b0;
   logic rst, valid, data, clear;
   logic        locked, error, locked4, error4;
   logic [31:0] ec, bc;
   logic [3:0]  ec4, bc4;

   always #5 clk = ~clk;

   lfsr_checker #(.N(N), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT), .WIN(WIN),
                  .UNLOCK_ERRS(UNLOCK), .CNT_W(32)) dut (
      .clk_i(clk), .reset_i(rst), .valid_i(valid), .data_i(data), .clear_i(clear),
      .locked_o(locked), .error_o(error), .err_count_o(ec), .bit_count_o(bc));

   lfsr_checker #(.N(N), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT), .WIN(WIN),
                  .UNLOCK_ERRS(UNLOCK), .CNT_W(4)) dut4 (
      .clk_i(clk), .reset_i(rst), .valid_i(valid), .data_i(data), .clear_i(clear),
      .locked_o(locked4), .error_o(error4), .err_count_o(ec4), .bit_count_o(bc4));

   int nvec  = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (sequence-level view) ----------------
   bit     m_hq[$];          // last N received/predicted bits, [0] oldest
   int     m_mode;           // 0 fill, 1 sync, 2 locked
   int     m_fcnt, m_match, m_wb, m_we;
   bit     m_err;
   longint m_ec, m_bc;

   task model_reset();
      m_hq.delete();
      for (int i = 0; i < N; i++) m_hq.push_back(1'b0);
      m_mode = 0; m_fcnt = 0; m_match = 0; m_wb = 0; m_we = 0;
      m_err = 0; m_ec = 0; m_bc = 0;
   endtask

   task model_step();
      bit p, nz, mis;
      m_err = 0;
      if (valid) begin
         p = 0; nz = 0;
         for (int i = 0; i < N; i++) begin
            if (TAPS[i]) p ^= m_hq[i];
            nz |= m_hq[i];
         end
         mis = (data != p);
         case (m_mode)
            0: begin
               void'(m_hq.pop_front()); m_hq.push_back(data);
               m_fcnt++;
               if (m_fcnt == N) begin m_mode = 1; m_match = 0; end
            end
            1: begin
               if (!mis && nz) begin
                  m_match++;
                  if (m_match == LOCK_COUNT) begin m_mode = 2; m_wb = 0; m_we = 0; end
               end else m_match = 0;
               void'(m_hq.pop_front()); m_hq.push_back(data);
            end
            default: begin
               m_bc++;
               m_wb++;
               if (mis) begin m_ec++; m_err = 1; m_we++; end
               void'(m_hq.pop_front()); m_hq.push_back(p);
               if (m_we == UNLOCK) begin m_mode = 0; m_fcnt = 0; m_wb = 0; m_we = 0; end
               else if (m_wb == WIN) begin m_wb = 0; m_we = 0; end
            end
         endcase
      end
      if (clear) begin m_ec = 0; m_bc = 0; end
   endtask

   initial model_reset();
   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("locked",  locked,  m_mode == 2);
         chk("error",   error,   m_err);
         chk("err_cnt", ec,      m_ec);
         chk("bit_cnt", bc,      m_bc);
         chk("locked4", locked4, m_mode == 2);
         chk("err4",    ec4,     (m_ec > 15) ? 15 : m_ec);
         chk("bit4",    bc4,     (m_bc > 15) ? 15 : m_bc);
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] gs;

   task automatic gen_bit(output logic b);
      b  = gs[0];
      gs = {^(gs & TAPS), gs[7:1]};
   endtask

   task automatic cyc(input logic v, input logic d, input logic c);
      valid = v; data = d; clear = c;
      @(posedge clk); #1;
   endtask

   task automatic send(input int n, input logic inv);
      logic b;
      for (int i = 0; i < n; i++) begin
         gen_bit(b);
         cyc(1'b1, b ^ inv, 1'b0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      gs  = 8'h01;
   endtask

   initial begin
      logic b;
      int   nv, nb;
      rst = 1'b0; valid = 1'b0; data = 1'b0; clear = 1'b0; gs = 8'h01;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_locked", locked, 0);
      chk("rst_error",  error,  0);
      chk("rst_errcnt", ec,     0);
      chk("rst_bitcnt", bc,     0);
      @(posedge clk); #1;
      rst = 1'b0;

      // T1 clean stream
      send(23, 1'b0);
      chk("t1_locked_23", locked, 0);
      send(1, 1'b0);
      chk("t1_locked_24", locked, 1);
      send(1000, 1'b0);
      chk("t1_errcnt", ec, 0);
      chk("t1_bitcnt", bc, 1000);

      // T2 single inverted bit
      send(1, 1'b1);
      chk("t2_error", error, 1);
      chk("t2_errcnt", ec, 1);
      chk("t2_locked", locked, 1);
      send(1, 1'b0);
      chk("t2_no_mult", error, 0);
      chk("t2_errcnt2", ec, 1);
      send(130, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("t2_clear", ec, 0);

      // T3 burst of 8 errors -> unlock, then relock
      for (int i = 0; i < 8; i++) begin
         send(1, 1'b1);
         chk("t3_error", error, 1);
      end
      chk("t3_unlocked", locked, 0);
      chk("t3_errcnt", ec, 8);
      send(23, 1'b0);
      chk("t3_relock_23", locked, 0);
      send(1, 1'b0);
      chk("t3_relock_24", locked, 1);

      // T4 random valid gaps
      do_reset();
      nv = 0;
      while (nv < 24) begin
         if ($urandom_range(0, 1) == 1) begin
            gen_bit(b); cyc(1'b1, b, 1'b0); nv++;
         end else begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         end
      end
      chk("t4_locked", locked, 1);
      nb = 0;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            gen_bit(b); cyc(1'b1, b, 1'b0); nb++;
         end else begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         end
      end
      chk("t4_errcnt", ec, 0);
      chk("t4_bitcnt", bc, nb);

      // T5 all-zero input never locks
      do_reset();
      for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'b0);
      chk("t5_zero_nolock", locked, 0);
      gs = 8'h01;
      send(24, 1'b0);
      chk("t5_locked", locked, 1);

      // T6 clear with coincident increment, async reset, saturation
      for (int i = 0; i < 3; i++) begin
         send(1, 1'b1);
         send(10, 1'b0);
      end
      chk("t6_errcnt3", ec, 3);
      gen_bit(b);
      cyc(1'b1, b, 1'b1);
      chk("t6_clr_err", ec, 0);
      chk("t6_clr_bit", bc, 0);
      chk("t6_clr_lock", locked, 1);
      rst = 1'b1;
      #1;
      chk("t6_async_rst", locked, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      gs  = 8'h01;
      send(24, 1'b0);
      chk("t6_relock", locked, 1);
      for (int i = 0; i < 20; i++) begin
         send(1, 1'b1);
         send(19, 1'b0);
      end
      chk("t6_sat4", ec4, 15);
      chk("t6_err32", ec, 20);
      chk("t6_lock_held", locked, 1);

      cyc(1'b0, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
`default_nettype wire
